// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer widths, Gray
// conversion and the write-side full compare.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int PTR_W = DEF_ADDR_WIDTH + 1;

  // Generic 32-bit forms; callers zero-extend
  // and truncate to their pointer width.
  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Upper zero bits keep the prefix XOR exact
  // for any narrower zero-extended Gray value.
  function automatic logic [31:0] gray2bin(
    input logic [31:0] g
  );
    logic [31:0] b;
    b = g;
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Full when the write pointer is exactly one
  // lap ahead: Gray(b + depth) flips the top
  // two Gray bits of Gray(b).
  function automatic logic ptr_full(
    input logic [31:0] wg,
    input logic [31:0] rg,
    input int unsigned pw
  );
    logic [31:0] msk;
    msk = 32'd3 << (pw - 2);
    return wg == (rg ^ msk);
  endfunction

endpackage

// File: rtl/fifo_gray_ptr.sv
// Binary + Gray pointer register pair with
// increment enable; shared by both FIFO sides.
// Ports: clk, reset (sync, high), inc,
//   bin/gray (registered), bin_next/gray_next.
module fifo_gray_ptr
  import fifo_pkg::*;
#(
  parameter int PW = PTR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [PW-1:0] bin,
  output logic [PW-1:0] gray,
  output logic [PW-1:0] bin_next,
  output logic [PW-1:0] gray_next
);

  always_comb begin
    bin_next  = bin + PW'(inc);
    gray_next = PW'(bin2gray(32'(bin_next)));
  end

  // gray is its own flop so the synchronizer
  // never sees a combinational glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Async FIFO write-side pointer, full/level flags
// and RAM write port, all in clk_src.
// Ports: clk_src, reset (sync, high), wr_en,
//   ovf_clr, rptr_gray_sync (synced read ptr);
//   out: wr_fire, wr_addr, wptr_gray, full,
//   almost_full, wr_count, overflow.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ALMOST_FULL_THRESH = 6
) (
  input  logic                  clk_src,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  ovf_clr,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  output logic                  wr_fire,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow
);

  localparam int AW = ADDR_WIDTH;
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wptr_bin;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rptr_bin;
  logic [PW-1:0] count_next;
  logic          full_next;
  logic          af_next;

  assign wr_fire = wr_en & ~full & ~reset;
  assign wr_addr = AW'(wptr_bin);

  fifo_gray_ptr #(
    .PW (PW)
  ) u_ptr (
    .clk       (clk_src),
    .reset     (reset),
    .inc       (wr_fire),
    .bin       (wptr_bin),
    .gray      (wptr_gray),
    .bin_next  (bin_next),
    .gray_next (gray_next)
  );

  // The synced read pointer lags the true one,
  // so both flags err toward "fuller".
  always_comb begin
    rptr_bin   = PW'(gray2bin(32'(rptr_gray_sync)));
    count_next = bin_next - rptr_bin;
    full_next  = ptr_full(32'(gray_next),
                          32'(rptr_gray_sync),
                          PW);
    af_next    = 32'(count_next)
                 >= 32'(ALMOST_FULL_THRESH);
  end

  always_ff @(posedge clk_src) begin
    if (reset) begin
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
    end else begin
      full        <= full_next;
      almost_full <= af_next;
      wr_count    <= count_next;
    end
  end

  // Set beats clear when both land together.
  always_ff @(posedge clk_src) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_en & full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: directed cases then
// random traffic against an occupancy model.
module tb_fifo_wptr_full;

  logic       clk_src = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] rptr_gray_sync = '0;
  logic       wr_fire;
  logic [2:0] wr_addr;
  logic [3:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_count;
  logic       overflow;

  fifo_wptr_full #(
    .ADDR_WIDTH         (3),
    .ALMOST_FULL_THRESH (6)
  ) dut (
    .clk_src        (clk_src),
    .reset          (reset),
    .wr_en          (wr_en),
    .ovf_clr        (ovf_clr),
    .rptr_gray_sync (rptr_gray_sync),
    .wr_fire        (wr_fire),
    .wr_addr        (wr_addr),
    .wptr_gray      (wptr_gray),
    .full           (full),
    .almost_full    (almost_full),
    .wr_count       (wr_count),
    .overflow       (overflow)
  );

  always #5 clk_src = ~clk_src;

  int n_chk = 0;
  int n_fail = 0;

  // Model: total writes mod 16 and flags
  // derived from occupancy arithmetic.
  int m_w = 0;
  int m_cnt = 0;
  bit m_full = 0;
  bit m_af = 0;
  bit m_ovf = 0;
  logic [3:0] prev_gray = '0;
  int g_tc = -1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] to_gray(int n);
    int v;
    v = n & 15;
    return 4'(v ^ (v >> 1));
  endfunction

  function automatic int from_gray(logic [3:0] g);
    for (int n = 0; n < 16; n++)
      if (to_gray(n) == g) return n;
    return 0;
  endfunction

  task automatic step(input bit we, input bit oc,
                      input logic [3:0] rp,
                      input bit rst);
    bit fire;
    wr_en = we;
    ovf_clr = oc;
    rptr_gray_sync = rp;
    reset = rst;
    @(negedge clk_src);
    fire = we && !m_full && !rst;
    chk("wr_fire", 32'(wr_fire), 32'(fire));
    chk("wr_addr", 32'(wr_addr), 32'(m_w % 8));
    if (g_tc >= 0)
      chk("no_wr_true_full",
          32'(wr_fire && g_tc >= 8), 0);
    @(posedge clk_src);
    if (rst) begin
      m_w = 0; m_cnt = 0;
      m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      if (we && m_full) m_ovf = 1;
      else if (oc) m_ovf = 0;
      m_w = (m_w + int'(fire)) % 16;
      m_cnt = (m_w - from_gray(rp) + 16) % 16;
      m_full = (m_cnt == 8);
      m_af = (m_cnt >= 6);
    end
    #1;
    chk("wptr_gray", 32'(wptr_gray),
        32'(to_gray(m_w)));
    chk("full", 32'(full), 32'(m_full));
    chk("almost_full", 32'(almost_full),
        32'(m_af));
    chk("wr_count", 32'(wr_count), 32'(m_cnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (!rst)
      chk("gray_hamming",
          32'($countones(wptr_gray ^ prev_gray) <= 1),
          1);
    prev_gray = wptr_gray;
  endtask

  logic [3:0] exp_seq [8] = '{
    4'b0001, 4'b0011, 4'b0010, 4'b0110,
    4'b0111, 4'b0101, 4'b0100, 4'b1100
  };

  initial begin
    int rt, s1, s2, tc;
    bit we, oc, rd, rst;
    @(posedge clk_src);
    #1;
    // 1: reset with write requested
    step(1, 0, 4'b0000, 1);
    step(1, 0, 4'b0000, 1);
    chk("rst_gray", 32'(wptr_gray), 0);
    // 2: eight writes, read side idle
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 4'b0000, 0);
      chk("seq_gray", 32'(wptr_gray),
          32'(exp_seq[i]));
      chk("seq_af", 32'(almost_full),
          32'(i >= 5));
    end
    chk("t2_full", 32'(full), 1);
    chk("t2_count", 32'(wr_count), 8);
    // 3: overflow set / set-beats-clear / clear
    step(1, 0, 4'b0000, 0);
    chk("t3_gray", 32'(wptr_gray), 32'(4'b1100));
    chk("t3_ovf", 32'(overflow), 1);
    step(1, 1, 4'b0000, 0);
    chk("t3_ovf_set_wins", 32'(overflow), 1);
    step(0, 1, 4'b0000, 0);
    chk("t3_ovf_clr", 32'(overflow), 0);
    // 4: one read becomes visible
    step(0, 0, 4'b0001, 0);
    chk("t4_full", 32'(full), 0);
    chk("t4_count", 32'(wr_count), 7);
    chk("t4_af", 32'(almost_full), 1);
    // 5: reader at 8, writer wraps past 15
    for (int i = 0; i < 8; i++)
      step(1, 0, 4'b1100, 0);
    chk("t5_gray", 32'(wptr_gray), 0);
    chk("t5_full", 32'(full), 1);
    chk("t5_count", 32'(wr_count), 8);
    // 6: random traffic, 2-stage synced reader
    rt = 8; s1 = 8; s2 = 8;
    for (int i = 0; i < 400; i++) begin
      rst = (i == 200 || i == 201);
      we = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 2) == 0);
      oc = ($urandom_range(0, 15) == 0);
      tc = (m_w - rt + 16) % 16;
      g_tc = tc;
      step(we, oc, to_gray(s2), rst);
      if (rst) begin
        rt = 0; s1 = 0; s2 = 0;
      end else begin
        if (rd && tc > 0) rt = (rt + 1) % 16;
        s2 = s1;
        s1 = rt;
      end
      tc = (m_w - rt + 16) % 16;
      chk("true_le_depth", 32'(tc <= 8), 1);
      chk("cnt_ge_true",
          32'(int'(wr_count) >= tc), 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
